// File: rtl/router_pkg.sv
// Shared constants and elaboration helpers for the 1xN router sync block.
package router_pkg;

    localparam int unsigned ROUTER_MAX_CH      = 8;
    localparam int unsigned ROUTER_DEF_TIMEOUT = 30;

    function automatic int unsigned router_clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Address width for n channels; never narrower than one bit.
    function automatic int unsigned router_addr_w(input int unsigned n);
        return (router_clog2(n) < 1) ? 1 : router_clog2(n);
    endfunction

endpackage

// File: rtl/router_timeout_ctr.sv
// Per-channel stall counter: emits a one-cycle soft_reset every TIMEOUT consecutive
// cycles in which the channel holds valid data that nobody reads.
module router_timeout_ctr #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    always_comb begin
        cnt_d   = '0;
        pulse_d = 1'b0;
        if (vld && !rd) begin
            if (cnt_q == LastCnt) begin
                pulse_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign soft_reset = pulse_q;

endmodule

// File: rtl/router_sync_n.sv
// Router sync/control: latches the packet destination, steers write enables to one of
// NUM_CH FIFOs, muxes back its full flag and raises per-channel timeout resets.
module router_sync_n
    import router_pkg::*;
#(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned ADDR_W  = router_addr_w(NUM_CH),
    parameter int unsigned TIMEOUT = ROUTER_DEF_TIMEOUT,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              detect_add,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    // One extra bit so NUM_CH itself is representable for the range check.
    localparam logic [ADDR_W:0] NumChW = (ADDR_W + 1)'(NUM_CH);

    logic [ADDR_W-1:0] dest_q, dest_d;
    logic              dest_vld_q, dest_vld_d;
    logic              addr_err_q, addr_err_d;

    always_comb begin
        dest_d     = dest_q;
        dest_vld_d = dest_vld_q;
        addr_err_d = addr_err_q;
        if (detect_add) begin
            if ({1'b0, data_in} < NumChW) begin
                dest_d     = data_in;
                dest_vld_d = 1'b1;
                addr_err_d = 1'b0;
            end else begin
                dest_vld_d = 1'b0;
                addr_err_d = 1'b1;
            end
        end else if (dest_vld_q && soft_reset[dest_q]) begin
            // Sink on the selected channel timed out: stop writing this packet.
            dest_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dest_q     <= '0;
            dest_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            dest_q     <= dest_d;
            dest_vld_q <= dest_vld_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign fifo_full = dest_vld_q ? full[dest_q] : 1'b0;
    assign write_enb = (write_enb_reg && dest_vld_q) ? (NUM_CH'(1) << dest_q) : '0;
    assign vld_out   = ~empty;
    assign addr_err  = addr_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        router_timeout_ctr #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_ctr (
            .clock      (clock),
            .reset      (reset),
            .vld        (vld_out[i]),
            .rd         (read_enb[i]),
            .soft_reset (soft_reset[i])
        );
    end

endmodule
